// File: rtl/uart_time_rx.sv
// uart_time_rx: 8N1 UART receiver feeding an ASCII "YYYY-MM-DD HH:MM:SS<CR|LF>"
// timestamp parser. Parsed fields are range-checked and published atomically
// with a one-cycle time_valid strobe; raw bytes are exposed for debug.
module uart_time_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        reset_n,        // active-high synchronous reset
    input  logic        rx_pin,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic [13:0] year,
    output logic [3:0]  month,
    output logic [4:0]  day,
    output logic [4:0]  hour,
    output logic [5:0]  minute,
    output logic [5:0]  second,
    output logic        time_valid,
    output logic        frame_err,
    output logic        parse_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] C_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx_byte;
    logic             r_rx_valid;
    logic             r_frame_err;

    // Two-flop synchroniser; resets to the idle (high) line level
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx_pin;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Bit-timing FSM: half-bit start qualification, then mid-bit sampling
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_rx_byte   <= '0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_sync) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == C_HALF_END) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        // A line that has gone high again was only a glitch
                        r_state   <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == C_BIT_END) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin // S_STOP
                    if (r_cnt == C_BIT_END) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        if (r_rx_sync) begin
                            r_rx_byte  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Parser
    // ------------------------------------------------------------------
    logic [4:0]  r_pos;
    logic        r_resync;
    logic [13:0] r_acc_year;
    logic [13:0] r_year;
    logic [3:0]  r_month;
    logic [4:0]  r_day;
    logic [4:0]  r_hour;
    logic [5:0]  r_minute;
    logic [5:0]  r_second;
    logic        r_time_valid;
    logic        r_parse_err;

    logic        w_is_digit;
    logic        w_is_eol;
    logic [3:0]  w_digit;
    logic        w_char_ok;
    logic        w_accept;
    logic        w_range_ok;
    logic [6:0]  w_acc [5];     // month, day, hour, minute, second

    assign w_is_digit = (r_rx_byte >= 8'h30) && (r_rx_byte <= 8'h39);
    assign w_is_eol   = (r_rx_byte == 8'h0D) || (r_rx_byte == 8'h0A);
    assign w_digit    = r_rx_byte[3:0];     // low nibble of '0'..'9' is the value

    // Expected character class for the current position
    always_comb begin
        w_char_ok = w_is_digit;
        case (r_pos)
            5'd4, 5'd7:   w_char_ok = (r_rx_byte == 8'h2D);
            5'd10:        w_char_ok = (r_rx_byte == 8'h20);
            5'd13, 5'd16: w_char_ok = (r_rx_byte == 8'h3A);
            5'd19:        w_char_ok = w_is_eol;
            default:      w_char_ok = w_is_digit;
        endcase
    end

    // Byte accepted into the string body (positions 0..18)
    assign w_accept = r_rx_valid && !r_resync && w_char_ok && (r_pos != 5'd19);

    // Two-digit fields: field gi occupies positions 5+3*gi and 6+3*gi
    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_field
            localparam logic [4:0] C_POS_HI = 5'(5 + 3 * gi);
            localparam logic [4:0] C_POS_LO = 5'(6 + 3 * gi);
            logic [6:0] r_acc;

            // Decimal accumulate on this field's digit positions; clear on a new string
            always_ff @(posedge clk) begin
                if (reset_n) begin
                    r_acc <= '0;
                end else if (w_accept) begin
                    if (r_pos == 5'd0) begin
                        r_acc <= '0;
                    end else if ((r_pos == C_POS_HI) || (r_pos == C_POS_LO)) begin
                        r_acc <= r_acc * 7'd10 + {3'd0, w_digit};
                    end
                end
            end

            assign w_acc[gi] = r_acc;
        end
    endgenerate

    assign w_range_ok = (w_acc[0] >= 7'd1) && (w_acc[0] <= 7'd12) &&
                        (w_acc[1] >= 7'd1) && (w_acc[1] <= 7'd31) &&
                        (w_acc[2] <= 7'd23) && (w_acc[3] <= 7'd59) &&
                        (w_acc[4] <= 7'd59);

    // Position tracking, error/resync handling and atomic output update
    always_ff @(posedge clk) begin
        if (reset_n) begin
            r_pos        <= '0;
            r_resync     <= 1'b0;
            r_acc_year   <= '0;
            r_year       <= 14'd2024;
            r_month      <= 4'd1;
            r_day        <= 5'd1;
            r_hour       <= '0;
            r_minute     <= '0;
            r_second     <= '0;
            r_time_valid <= 1'b0;
            r_parse_err  <= 1'b0;
        end else begin
            r_time_valid <= 1'b0;
            r_parse_err  <= 1'b0;
            if (r_rx_valid) begin
                if (r_resync) begin
                    if (w_is_eol) begin
                        r_resync <= 1'b0;
                        r_pos    <= '0;
                    end
                end else if ((r_pos == 5'd0) && w_is_eol) begin
                    // Second half of a CRLF pair, or a blank line: ignore
                    r_pos <= '0;
                end else if (!w_char_ok) begin
                    r_parse_err <= 1'b1;
                    r_pos       <= '0;
                    // An early line end already marks the next string boundary
                    r_resync    <= !w_is_eol;
                end else if (r_pos == 5'd19) begin
                    r_pos <= '0;
                    if (w_range_ok) begin
                        r_year       <= r_acc_year;
                        r_month      <= w_acc[0][3:0];
                        r_day        <= w_acc[1][4:0];
                        r_hour       <= w_acc[2][4:0];
                        r_minute     <= w_acc[3][5:0];
                        r_second     <= w_acc[4][5:0];
                        r_time_valid <= 1'b1;
                    end else begin
                        r_parse_err <= 1'b1;
                    end
                end else begin
                    r_pos <= r_pos + 1'b1;
                    if (r_pos == 5'd0) begin
                        r_acc_year <= {10'd0, w_digit};
                    end else if (r_pos <= 5'd3) begin
                        r_acc_year <= r_acc_year * 14'd10 + {10'd0, w_digit};
                    end
                end
            end
        end
    end

    assign rx_byte       = r_rx_byte;
    assign rx_byte_valid = r_rx_valid;
    assign frame_err     = r_frame_err;
    assign year          = r_year;
    assign month         = r_month;
    assign day           = r_day;
    assign hour          = r_hour;
    assign minute        = r_minute;
    assign second        = r_second;
    assign time_valid    = r_time_valid;
    assign parse_err     = r_parse_err;

endmodule
